// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path: FSM states,
// switch filter codes and the RGB565 field MSB positions within each byte.
package cam_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CAP_HI = 2'd1,
      CAP_LO = 2'd2
   } cap_state_t;

   localparam logic [7:0] FLT_NONE  = 8'd0;
   localparam logic [7:0] FLT_INV   = 8'd1;
   localparam logic [7:0] FLT_RED   = 8'd2;
   localparam logic [7:0] FLT_GREEN = 8'd3;
   localparam logic [7:0] FLT_BLUE  = 8'd4;

   // RGB565 arrives as byte1 = RRRRRGGG, byte2 = GGGBBBBB.
   localparam int R_MSB = 7;  // in byte1
   localparam int G_MSB = 2;  // in byte1
   localparam int B_MSB = 4;  // in byte2

endpackage

// File: rtl/rgb565_to_rgb111.sv
// Combinational RGB565 -> RGB111 reduction (MSB of each field) followed by
// the switch-selected colour filter. Shared with the preview path.
module rgb565_to_rgb111
   import cam_pkg::*;
#(
   parameter int DW = 3
) (
   input  logic [7:0]    byte1,
   input  logic [7:0]    byte2,
   input  logic [7:0]    filter,
   output logic [DW-1:0] pixel
);

   logic [DW-1:0] raw;
   logic          unused_bits;

   assign raw         = {byte1[R_MSB], byte1[G_MSB], byte2[B_MSB]};
   assign unused_bits = ^{byte1, byte2};

   always_comb begin
      // NOTE: assigning a default before the case gives every path a value, so no latch is inferred.
      pixel = raw;
      case (filter)
         FLT_NONE:  pixel = raw;
         FLT_INV:   pixel = ~raw;
         FLT_RED:   pixel = {raw[2], 2'b00};
         FLT_GREEN: pixel = {1'b0, raw[1], 1'b0};
         FLT_BLUE:  pixel = {2'b00, raw[0]};
         default:   pixel = raw;
      endcase
   end

endmodule

// File: rtl/cam_capture.sv
// OV7670 RGB565 byte-stream capture into frame-buffer writes: one frame per
// vsync period, saturating pixel counter with a sticky overflow flag.
module cam_capture
   import cam_pkg::*;
#(
   parameter int AW    = 15,
   parameter int DW    = 3,
   parameter int IMG_W = 160,
   parameter int IMG_H = 120
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          capture_en,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   input  logic [7:0]    filter,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_wr,
   output logic          busy,
   output logic          frame_done,
   output logic          overflow
);

   // One extra bit so the counter can hold IMG_W*IMG_H even when it equals 2**AW.
   localparam logic [AW:0] NPIX = (AW+1)'(IMG_W * IMG_H);

   cap_state_t    state, state_next;
   logic          vsync_q;
   logic          frame_start, frame_end;
   logic          start_capture, load_byte1, pixel_valid;
   logic [7:0]    byte1;
   logic [AW:0]   count;
   logic [DW-1:0] pixel;

   assign frame_start = vsync_q & ~vsync;
   assign frame_end   = ~vsync_q & vsync;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (frame_start && capture_en) state_next = CAP_HI;
         CAP_HI:  if (frame_end)                 state_next = IDLE;
                  else if (href)                 state_next = CAP_LO;
         CAP_LO:  state_next = frame_end ? IDLE : CAP_HI;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state != IDLE);
      start_capture = (state == IDLE) && frame_start && capture_en;
      load_byte1    = (state == CAP_HI) && href;
      pixel_valid   = (state == CAP_LO) && href;
   end

   rgb565_to_rgb111 #(
      .DW(DW)
   ) u_conv (
      .byte1 (byte1),
      .byte2 (px_data),
      .filter(filter),
      .pixel (pixel)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q    <= 1'b0;
         byte1      <= '0;
         count      <= '0;
         mem_addr   <= '0;
         mem_data   <= '0;
         mem_wr     <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         mem_wr     <= 1'b0;
         frame_done <= busy && frame_end;

         if (start_capture) begin
            count    <= '0;
            overflow <= 1'b0;
         end

         if (load_byte1) byte1 <= px_data;

         // A pixel completing on the same edge as vsync rise is still written.
         if (pixel_valid) begin
            if (count < NPIX) begin
               mem_wr   <= 1'b1;
               mem_addr <= count[AW-1:0];
               mem_data <= pixel;
               count    <= count + 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture: expected writes and frame_done pulses are
// queued as stimulus is driven and matched against DUT outputs each cycle.
module tb_cam_capture;

   localparam int AW    = 15;
   localparam int DW    = 3;
   localparam int IMG_W = 160;
   localparam int IMG_H = 120;
   localparam int NPIX  = IMG_W * IMG_H;

   logic          clk = 1'b0;
   logic          reset;
   logic          capture_en;
   logic          vsync;
   logic          href;
   logic [7:0]    px_data;
   logic [7:0]    filter;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wr;
   logic          busy;
   logic          frame_done;
   logic          overflow;

   typedef struct {
      int         cyc;
      int         addr;
      logic [2:0] data;
   } wr_t;

   typedef struct {
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] flt;
      logic [2:0] exp;
   } vec_t;

   wr_t wr_q[$];
   int  fd_q[$];

   int  cyc       = 0;
   int  n_checks  = 0;
   int  n_errors  = 0;
   int  n_writes  = 0;
   int  n_fd      = 0;
   int  exp_addr  = 0;
   bit  capturing = 1'b0;

   vec_t vecs [7] = '{
      '{8'h80, 8'h00, 8'd0, 3'b100},
      '{8'h80, 8'h00, 8'd1, 3'b011},
      '{8'h80, 8'h00, 8'd2, 3'b100},
      '{8'h80, 8'h00, 8'd3, 3'b000},
      '{8'h80, 8'h00, 8'd4, 3'b000},
      '{8'h80, 8'h00, 8'd9, 3'b100},
      '{8'h04, 8'h10, 8'd0, 3'b011}
   };

   always #5 clk = ~clk;

   cam_capture #(
      .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .capture_en(capture_en),
      .vsync     (vsync),
      .href      (href),
      .px_data   (px_data),
      .filter    (filter),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_wr    (mem_wr),
      .busy      (busy),
      .frame_done(frame_done),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2:0] ref_pixel(input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [7:0] flt);
      logic [2:0] p;
      p = {b1[7], b1[2], b2[4]};
      case (flt)
         8'd1:    return ~p;
         8'd2:    return {p[2], 2'b00};
         8'd3:    return {1'b0, p[1], 1'b0};
         8'd4:    return {2'b00, p[0]};
         default: return p;
      endcase
   endfunction

   // Monitor: sample one time unit after each rising edge.
   always @(posedge clk) begin
      wr_t e;
      cyc++;
      #1;
      if (mem_wr === 1'b1) begin
         n_writes++;
         check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
         if (wr_q.size() != 0) begin
            e = wr_q.pop_front();
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
            check("wr_addr", 32'(mem_addr), 32'(e.addr));
            check("wr_data", 32'(mem_data), 32'(e.data));
         end
      end
      if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
         check("wr_missing", 32'(mem_wr), 32'd1);
         void'(wr_q.pop_front());
      end
      if (frame_done === 1'b1) begin
         n_fd++;
         check("fd_expected", 32'(fd_q.size() != 0), 32'd1);
         if (fd_q.size() != 0) check("fd_cycle", 32'(cyc), 32'(fd_q.pop_front()));
         check("busy_at_done", 32'(busy), 32'd0);
      end
      if (fd_q.size() != 0 && fd_q[0] <= cyc) begin
         check("fd_missing", 32'(frame_done), 32'd1);
         void'(fd_q.pop_front());
      end
   end

   task automatic send_pixel_x(input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] flt, input logic [2:0] exp);
      wr_t e;
      @(negedge clk);
      href    = 1'b1;
      px_data = b1;
      @(negedge clk);
      px_data = b2;
      filter  = flt;
      if (capturing) begin
         if (exp_addr < NPIX) begin
            e.cyc  = cyc + 1;
            e.addr = exp_addr;
            e.data = exp;
            wr_q.push_back(e);
         end
         exp_addr++;
      end
   endtask

   task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] flt);
      send_pixel_x(b1, b2, flt, ref_pixel(b1, b2, flt));
   endtask

   task automatic row_end();
      @(negedge clk);
      href    = 1'b0;
      px_data = 8'h00;
   endtask

   task automatic send_frame_rows(input int rows, input bit rnd_filter);
      for (int r = 0; r < rows; r++) begin
         for (int p = 0; p < IMG_W; p++)
            send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       rnd_filter ? 8'($urandom_range(0, 9)) : 8'd0);
         row_end();
      end
   endtask

   task automatic vsync_rise();
      @(negedge clk);
      href  = 1'b0;
      vsync = 1'b1;
      if (capturing) fd_q.push_back(cyc + 1);
      capturing = 1'b0;
   endtask

   task automatic vsync_fall(input bit en);
      @(negedge clk);
      vsync      = 1'b0;
      capture_en = en;
      capturing  = en;
      if (en) exp_addr = 0;
   endtask

   task automatic vsync_pulse(input bit en);
      vsync_rise();
      repeat (2) @(negedge clk);
      vsync_fall(en);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit exceeded at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w0;
      reset      = 1'b1;
      capture_en = 1'b0;
      vsync      = 1'b0;
      href       = 1'b0;
      px_data    = 8'h00;
      filter     = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", 32'(mem_data), 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;

      // Full frame, filter 0.
      vsync_pulse(1'b1);
      @(negedge clk);
      check("busy_frame1", 32'(busy), 32'd1);
      send_frame_rows(IMG_H, 1'b0);
      check("ovf_frame1", 32'(overflow), 32'd0);
      vsync_pulse(1'b1);
      @(negedge clk);
      check("frame1_writes", 32'(n_writes), 32'(NPIX));
      check("frame1_done_count", 32'(n_fd), 32'd1);

      // Filter table, odd byte count, pixel coinciding with vsync rise.
      for (int i = 0; i < 7; i++) send_pixel_x(vecs[i].b1, vecs[i].b2, vecs[i].flt, vecs[i].exp);
      row_end();
      send_pixel(8'h84, 8'h10, 8'd0);
      @(negedge clk);
      px_data = 8'hFF;
      row_end();
      send_pixel_x(8'h00, 8'h00, 8'd0, 3'b000);
      row_end();
      begin
         wr_t e;
         @(negedge clk);
         href    = 1'b1;
         px_data = 8'h80;
         @(negedge clk);
         px_data = 8'h10;
         filter  = 8'd0;
         vsync   = 1'b1;
         e.cyc   = cyc + 1;
         e.addr  = exp_addr;
         e.data  = 3'b101;
         wr_q.push_back(e);
         fd_q.push_back(cyc + 1);
         capturing = 1'b0;
         @(negedge clk);
         href = 1'b0;
      end
      repeat (2) @(negedge clk);

      // Frame skipped with capture_en low, then resumed.
      vsync_fall(1'b0);
      for (int i = 0; i < 3; i++) send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'd0);
      row_end();
      check("busy_skipped", 32'(busy), 32'd0);
      vsync_pulse(1'b1);
      @(negedge clk);
      check("busy_resumed", 32'(busy), 32'd1);
      send_pixel(8'h04, 8'h10, 8'd0);
      capture_en = 1'b0;
      send_pixel(8'h80, 8'h00, 8'd1);
      row_end();
      check("busy_after_en_low", 32'(busy), 32'd1);

      // Overflow frame: one pixel too many, then a second extra.
      vsync_pulse(1'b1);
      w0 = n_writes;
      send_frame_rows(IMG_H, 1'b1);
      send_pixel(8'hFF, 8'hFF, 8'd0);
      row_end();
      check("ovf_set", 32'(overflow), 32'd1);
      send_pixel(8'hFF, 8'hFF, 8'd0);
      row_end();
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_frame_writes", 32'(n_writes - w0), 32'(NPIX));
      vsync_pulse(1'b1);
      @(negedge clk);
      check("ovf_cleared", 32'(overflow), 32'd0);
      check("busy_frame5", 32'(busy), 32'd1);

      // Reset mid-frame with byte2 on the bus.
      send_pixel(8'h00, 8'h00, 8'd0);
      send_pixel(8'h84, 8'h10, 8'd0);
      @(negedge clk);
      px_data = 8'hFF;
      @(negedge clk);
      px_data = 8'hFF;
      check("busy_before_reset", 32'(busy), 32'd1);
      reset     = 1'b1;
      capturing = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      href  = 1'b0;
      check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_mem_data", 32'(mem_data), 32'd0);
      check("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_frame_done", 32'(frame_done), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 2; i++) send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'd0);
      row_end();
      check("busy_after_reset", 32'(busy), 32'd0);
      vsync_pulse(1'b1);
      @(negedge clk);
      check("busy_after_pulse", 32'(busy), 32'd1);
      send_pixel(8'h80, 8'h00, 8'd2);
      row_end();
      vsync_rise();
      repeat (4) @(negedge clk);

      check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
      check("fd_queue_drained", 32'(fd_q.size()), 32'd0);
      check("frame_done_total", 32'(n_fd), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cam_capture.md
# cam_capture

Pixel-capture stage that sits directly upstream of the dual-port frame buffer's write port. It samples an OV7670-style RGB565 byte stream (vsync/href/8-bit data, synchronous to the camera pixel clock), reduces each pixel to RGB111, and applies the switch-selected colour filter. It then produces the buffer write address, data and write strobe. One full frame is written per vsync period while capture is enabled.

## Interface
- AW, 15, buffer address width.
- DW, 3, pixel width; fixed at 3, one bit each for R, G, B.
- IMG_W, 160, pixels per row.
- IMG_H, 120, rows per frame; IMG_W*IMG_H must be ≤ 2**AW.

Ports:
- clk  in  1  camera pixel clock; the single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- capture_en  in  1  level; a frame is captured only if high at frame start.
- vsync  in  1  camera vsync; high means vertical blanking.
- href  in  1  camera href; high means row bytes valid.
- px_data  in  8  camera byte.
- filter  in  8  colour-filter code from switches.
- mem_addr  out  AW  buffer write address.
- mem_data  out  DW  RGB111 pixel, bit 2 = R, bit 1 = G, bit 0 = B.
- mem_wr  out  1  one-cycle write strobe.
- busy  out  1  high while a frame is being captured.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- overflow  out  1  sticky; more than IMG_W*IMG_H pixels arrived in a frame.

## Operation
- States: IDLE, CAP_HI (expect first byte), CAP_LO (first byte held).
- vsync_q is registered vsync, reset to 0. Frame start is vsync_q=1 and vsync=0.
- IDLE → CAP_HI on frame start with capture_en=1. At that point, pixel counter ← 0 and overflow ← 0. Frame start with capture_en=0 leaves the block in IDLE and skips the frame.
- CAP_HI with href=1: latch byte1 ← px_data, go to CAP_LO.
- CAP_LO with href=1: form the pixel from byte1 and px_data, go to CAP_HI.
- CAP_LO with href=0: discard the partial pixel, go to CAP_HI.
- Pixel conversion, unfiltered: R = byte1[7], G = byte1[2], B = byte2[4] (MSB of each 565 field).
- Filter, sampled with byte2:
  - 0 = pass.
  - 1 = invert all three bits.
  - 2 = {R,0,0}.
  - 3 = {0,G,0}.
  - 4 = {0,0,B}.
  - Any other code = pass.
- Write: if counter < IMG_W*IMG_H, assert mem_wr with mem_addr = counter, then increment counter. Otherwise suppress the write and set overflow.
- End of frame is vsync rising (vsync_q=0, vsync=1) in CAP_HI or CAP_LO. It returns the FSM to IDLE and pulses frame_done. A pending byte1 is dropped.
- busy = (state ≠ IDLE).
- Pixel counts below IMG_W*IMG_H at end of frame are legal; the unwritten addresses keep their old contents.

## Timing
- Reset values: mem_addr=0, mem_data=0, mem_wr=0, busy=0, frame_done=0, overflow=0, state=IDLE, vsync_q=0.
- Because vsync_q resets to 0, a reset in mid-frame waits for a complete vsync pulse before the next capture.
- Reset asserted mid-frame forces the reset values on the next edge. No write is issued in that cycle.
- Latency: when byte2 is sampled at edge N, mem_wr/mem_addr/mem_data are valid from edge N+1 for exactly one cycle. The buffer's negedge write sees stable values.
- Throughput: at most one write per 2 clocks. mem_addr and mem_data hold their last values when mem_wr=0.
- Address wrap: none. The counter saturates at IMG_W*IMG_H, and the last written address is IMG_W*IMG_H−1 (19199 at default parameters).
- frame_done is asserted on the edge after vsync rises. busy falls on the same edge.
- If byte2 and vsync rise arrive on the same edge, the pixel is written and the frame then ends; frame_done and mem_wr are asserted together.
- capture_en falling mid-frame has no effect until the next frame start.

## Structure
- Shared package cam_pkg holds:
  - the state enum (IDLE, CAP_HI, CAP_LO);
  - filter code constants FLT_NONE=0, FLT_INV=1, FLT_RED=2, FLT_GREEN=3, FLT_BLUE=4;
  - RGB565 MSB bit positions.
- One combinational sub-module, rgb565_to_rgb111, converts {byte1, byte2, filter} to the DW-bit pixel. It is shared with any future on-screen preview path.
- The top level holds the FSM, vsync edge detect, pixel counter, overflow flag and output registers.

## Test plan
- Reset, then one full 160×120 frame with capture_en=1 and filter=0. Expect exactly 19200 mem_wr pulses at addresses 0…19199 in order, one frame_done, and overflow=0.
- Byte pair 0x80,0x00 sent with filter 0, 1, 2, 3, 4 and 9. Expect mem_data 3'b100, 3'b011, 3'b100, 3'b000, 3'b000, 3'b100.
- Byte pair 0x04,0x10 with filter=0 → mem_data=3'b011. Verify mem_wr appears exactly one cycle after byte2 is sampled.
- Frame of 19201 pixels → writes stop after address 19199 and overflow=1. Overflow clears at the next frame start.
- capture_en=0 at frame start → no mem_wr and no frame_done for that frame. capture_en=1 at the next vsync fall → capture resumes at address 0.
- Row with an odd byte count, and a reset asserted mid-frame:
  - odd byte count → the dangling byte is dropped;
  - reset mid-frame → outputs go to reset values, and capture restarts only after the next full vsync pulse.
